// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// The package name fifo_arb_pkg is used by every file in this slice.
package fifo_arb_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_t;

   localparam int STALL_CNT_W = 16;

   function automatic int grant_w(input int n);
      return $clog2(n);
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester handshake plus the FIFO write-domain port.
// The arbiter uses the slave modport; producers and the FIFO side use master.
interface fifo_wr_arbiter_if #(
   parameter int DATA_WIDTH = 8,
   parameter int N_REQ      = 4
);
   logic [N_REQ-1:0]            req_valid;
   logic [N_REQ*DATA_WIDTH-1:0] req_data;
   logic [N_REQ-1:0]            req_last;
   logic [N_REQ-1:0]            req_ready;
   logic                        wfull;
   logic                        half_full;
   logic                        winc;
   logic [DATA_WIDTH-1:0]       wdata;

   modport master (
      output req_valid, req_data, req_last, wfull, half_full,
      input  req_ready, winc, wdata
   );

   modport slave (
      input  req_valid, req_data, req_last, wfull, half_full,
      output req_ready, winc, wdata
   );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotating-priority picker: first eligible index at or above rr_ptr, with wrap.
// Purely combinational.
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int GW    = grant_w(N_REQ)
) (
   input  logic [N_REQ-1:0] eligible,
   input  logic [GW-1:0]    rr_ptr,
   output logic [GW-1:0]    pick,
   output logic             any
);

   logic [GW:0]   sum;
   logic [GW-1:0] idx;

   // Scan from the far end so the candidate closest to rr_ptr is written last.
   always_comb begin
      pick = '0;
      any  = 1'b0;
      sum  = '0;
      idx  = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         sum = {1'b0, rr_ptr} + (GW+1)'(k);
         if (sum >= (GW+1)'(N_REQ)) sum = sum - (GW+1)'(N_REQ);
         idx = sum[GW-1:0];
         if (eligible[idx]) begin
            pick = idx;
            any  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one async-FIFO write port among N_REQ producers.
// Optional FIFO_WR_ARB_STALL_CNT_EN adds a saturating wfull-stall counter output.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int               DATA_WIDTH = 8,
   parameter int               N_REQ      = 4,
   parameter int               MAX_BURST  = 16,
   parameter logic [N_REQ-1:0] PRIO_MASK  = N_REQ'(1),
   localparam int              GW         = grant_w(N_REQ),
   localparam int              BCW        = $clog2(MAX_BURST + 1)
) (
   input  logic                   wclk,
   input  logic                   wrst,
   fifo_wr_arbiter_if.slave       bus,
   output logic [GW-1:0]          grant_id,
   output logic                   busy
`ifdef FIFO_WR_ARB_STALL_CNT_EN
   ,
   output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

   localparam logic [0:0] S_IDLE  = IDLE;
   localparam logic [0:0] S_BURST = BURST;

   logic [0:0]       state_q, state_d;
   logic [GW-1:0]    rr_ptr_q, rr_ptr_d;
   logic [GW-1:0]    grant_q, grant_d;
   logic [BCW-1:0]   beat_cnt_q, beat_cnt_d;
   logic [N_REQ-1:0] eligible;
   logic [GW-1:0]    pick;
   logic             pick_any;
   logic             in_burst;
   logic             g_valid;
   logic             g_last;
   logic             accept;

   assign eligible = bus.req_valid & (bus.half_full ? PRIO_MASK : {N_REQ{1'b1}});
   assign in_burst = (state_q == S_BURST);
   assign g_valid  = bus.req_valid[grant_q];
   assign g_last   = bus.req_last[grant_q];
   // Reset gates the strobe so an abandoned burst never writes in the reset cycle.
   assign accept   = in_burst & g_valid & ~bus.wfull & ~wrst;
   assign busy     = in_burst;
   assign grant_id = grant_q;

   rr_pick #(.N_REQ(N_REQ), .GW(GW)) u_rr_pick (
      .eligible (eligible),
      .rr_ptr   (rr_ptr_q),
      .pick     (pick),
      .any      (pick_any)
   );

   always_comb begin
      bus.winc      = accept;
      bus.req_ready = '0;
      if (in_burst && !wrst) bus.req_ready[grant_q] = ~bus.wfull;
      bus.wdata = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant_q == GW'(i)) bus.wdata = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      grant_d    = grant_q;
      beat_cnt_d = beat_cnt_q;
      case (state_q)
         S_IDLE: begin
            if (pick_any) begin
               state_d    = S_BURST;
               grant_d    = pick;
               beat_cnt_d = '0;
            end
         end
         default: begin
            if (accept) beat_cnt_d = beat_cnt_q + 1'b1;
            // A bubble, a final beat or a full burst quota all release the grant.
            if (!g_valid || (accept && (g_last || beat_cnt_q == BCW'(MAX_BURST - 1)))) begin
               state_d  = S_IDLE;
               rr_ptr_d = (grant_q == GW'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge wclk) begin
      if (wrst) begin
         state_q    <= S_IDLE;
         rr_ptr_q   <= '0;
         grant_q    <= '0;
         beat_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         grant_q    <= grant_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

`ifdef FIFO_WR_ARB_STALL_CNT_EN
   logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (in_burst && g_valid && bus.wfull && stall_cnt_q != {STALL_CNT_W{1'b1}})
         stall_cnt_d = stall_cnt_q + 1'b1;
   end

   always_ff @(posedge wclk) begin
      if (wrst) stall_cnt_q <= '0;
      else      stall_cnt_q <= stall_cnt_d;
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: directed scenarios then randomized traffic
// against a cycle-level behavioural model of the arbitration rules.
module tb_fifo_wr_arbiter;
   import fifo_arb_pkg::*;

   localparam int DW = 8;
   localparam int N  = 4;
   localparam int MB = 16;
   localparam int GW = grant_w(N);
   localparam logic [N-1:0] PM = 4'b0001;

   logic          clk = 1'b0;
   logic          rst;
   logic [GW-1:0] grant_id;
   logic          busy;
`ifdef FIFO_WR_ARB_STALL_CNT_EN
   logic [15:0]   stall_cnt;
`endif

   fifo_wr_arbiter_if #(.DATA_WIDTH(DW), .N_REQ(N)) bus ();

   fifo_wr_arbiter #(
      .DATA_WIDTH (DW),
      .N_REQ      (N),
      .MAX_BURST  (MB),
      .PRIO_MASK  (PM)
   ) dut (
      .wclk     (clk),
      .wrst     (rst),
      .bus      (bus),
      .grant_id (grant_id),
      .busy     (busy)
`ifdef FIFO_WR_ARB_STALL_CNT_EN
      ,
      .stall_cnt (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int winc_seen = 0;

   typedef struct {
      int            g;
      logic [DW-1:0] data;
   } exp_t;
   exp_t expq[$];

   // producer state
   int            beats_left[N];
   int            blen[N];
   int            bidx[N];
   logic [DW-1:0] pdata[N];
   logic [N-1:0]  bubble;
   logic          wf, hf, rst_i;

   // reference model state
   bit m_busy;
   int m_g, m_ptr, m_cnt, m_stall;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every write strobe must match the oldest predicted write.
   always @(negedge clk) begin
      if (bus.winc === 1'b1) begin
         winc_seen++;
         if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL write_unexpected: got winc=1 data=%0h expected no write at %0t", bus.wdata, $time);
         end else begin
            exp_t e;
            e = expq.pop_front();
            check("wdata", 32'(bus.wdata), 32'(e.data));
            check("write_grant", 32'(grant_id), 32'(e.g));
         end
      end
   end

   task automatic step();
      logic [N-1:0] v, l, e_ready, elig;
      bit w, ex;
      int pick, j;
      for (int i = 0; i < N; i++) begin
         v[i] = (beats_left[i] > 0) && !bubble[i];
         l[i] = (blen[i] != 0) && (bidx[i] == blen[i] - 1);
         bus.req_data[i*DW +: DW] = pdata[i];
      end
      bus.req_valid = v;
      bus.req_last  = l;
      bus.wfull     = wf;
      bus.half_full = hf;
      rst           = rst_i;
      e_ready = '0; w = 0; ex = 0; pick = -1;
      if (!rst_i) begin
         if (!m_busy) begin
            elig = v & (hf ? PM : {N{1'b1}});
            for (int k = 0; k < N; k++) begin
               j = (m_ptr + k) % N;
               if (pick < 0 && elig[j]) pick = j;
            end
         end else begin
            e_ready[m_g] = !wf;
            w  = v[m_g] && !wf;
            ex = (w && (l[m_g] || m_cnt == MB - 1)) || !v[m_g];
         end
      end
      if (w) expq.push_back('{m_g, pdata[m_g]});
      @(negedge clk);
      check("req_ready", 32'(bus.req_ready), 32'(e_ready));
      check("winc", 32'(bus.winc), 32'(w));
      check("busy", 32'(busy), 32'(m_busy));
      check("grant_id", 32'(grant_id), 32'(m_g));
`ifdef FIFO_WR_ARB_STALL_CNT_EN
      check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
`endif
      @(posedge clk);
      #1;
      if (rst_i) begin
         m_busy = 0; m_g = 0; m_ptr = 0; m_cnt = 0; m_stall = 0;
      end else if (!m_busy) begin
         if (pick >= 0) begin
            m_busy = 1; m_g = pick; m_cnt = 0;
         end
      end else begin
         if (wf && v[m_g] && m_stall < 65535) m_stall++;
         if (w) begin
            beats_left[m_g]--;
            bidx[m_g] = l[m_g] ? 0 : bidx[m_g] + 1;
            pdata[m_g] = DW'($urandom);
            m_cnt++;
         end
         if (ex) begin
            m_busy = 0;
            m_ptr  = (m_g + 1) % N;
         end
      end
   endtask

   task automatic run(input int n);
      for (int c = 0; c < n; c++) step();
   endtask

   task automatic set_req(input int i, input int beats, input int bl);
      beats_left[i] = beats;
      blen[i]       = bl;
      bidx[i]       = 0;
   endtask

   task automatic clear_and_reset();
      for (int i = 0; i < N; i++) set_req(i, 0, 0);
      bubble = '0; wf = 0; hf = 0;
      rst_i = 1; step(); rst_i = 0;
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not reach the end within the time limit");
      $fatal(1, "timeout");
   end

   initial begin
      int w0;
      for (int i = 0; i < N; i++) begin
         set_req(i, 0, 0);
         pdata[i] = DW'($urandom);
      end
      bubble = '0; wf = 0; hf = 0; rst_i = 1;
      m_busy = 0; m_g = 0; m_ptr = 0; m_cnt = 0; m_stall = 0;
      bus.req_valid = '0; bus.req_last = '0; bus.req_data = '0;
      bus.wfull = 1'b0; bus.half_full = 1'b0; rst = 1'b1;
      @(posedge clk); @(posedge clk); #1;

      // reset state
      run(2);
      rst_i = 0;

      // reset mid-burst of requester 1, then scan restarts from 0
      set_req(1, 10, 0);
      run(4);
      rst_i = 1; step(); rst_i = 0;
      set_req(3, 1, 1);
      run(20);

      // round robin: grant order 0,1,2,3,0 with two-beat bursts
      clear_and_reset();
      set_req(0, 4, 2); set_req(1, 2, 2); set_req(2, 2, 2); set_req(3, 2, 2);
      w0 = winc_seen;
      run(15);
      check("rr_winc_count", 32'(winc_seen - w0), 32'd10);

      // MAX_BURST release, rotation, regained grant
      set_req(2, 20, 0); set_req(3, 2, 2);
      w0 = winc_seen;
      run(30);
      check("maxburst_winc_count", 32'(winc_seen - w0), 32'd22);

      // wfull stall for 5 cycles
      clear_and_reset();
      set_req(0, 6, 6);
      run(3);
      wf = 1;
      w0 = winc_seen;
      run(5);
      check("stall_winc_count", 32'(winc_seen - w0), 32'd0);
`ifdef FIFO_WR_ARB_STALL_CNT_EN
      check("stall_cnt_five", 32'(stall_cnt), 32'd5);
`endif
      wf = 0;
      run(8);

      // half_full gating
      clear_and_reset();
      hf = 1;
      set_req(1, 2, 2); set_req(2, 2, 2); set_req(3, 2, 2);
      run(3);
      set_req(0, 2, 2);
      run(8);
      hf = 0;
      run(12);

      // half_full rising mid-burst of requester 3
      clear_and_reset();
      set_req(3, 5, 5);
      run(2);
      hf = 1;
      set_req(0, 2, 2); set_req(1, 2, 2);
      run(12);
      hf = 0;
      run(10);

      // randomized traffic
      clear_and_reset();
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++) begin
            if (beats_left[i] == 0 && $urandom_range(0, 9) == 0)
               set_req(i, $urandom_range(1, 24), ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 8));
            bubble[i] = ($urandom_range(0, 9) == 0);
         end
         wf = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 19) == 0) hf = ~hf;
         rst_i = ($urandom_range(0, 199) == 0);
         step();
      end
      rst_i = 0;
      clear_and_reset();
      run(3);
      check("queue_drain", 32'(expq.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares the single write port of the async FIFO (the winc/wfull/half_full write-domain interface) between N_REQ producers in the write clock domain.
- Round-robin burst arbitration with valid/ready handshake per requester.
- Back-pressure from wfull.
- When the FIFO is half full, new grants go only to priority requesters.
- Sits directly in front of the write-pointer/full logic; drives its winc and the FIFO write data.

Parameters:
- DATA_WIDTH, 8, width of one FIFO write word
- N_REQ, 4, number of requesters (2..16)
- MAX_BURST, 16, max accepted beats per grant (1..256)
- PRIO_MASK, 4'b0001 (N_REQ bits), requesters still eligible for new grants while half_full=1

Ports:
- wclk  input  1  write-domain clock
- wrst  input  1  synchronous, active-high reset
- req_valid  input  N_REQ  per-requester data valid
- req_data  input  N_REQ*DATA_WIDTH  packed data; requester i at [i*DATA_WIDTH +: DATA_WIDTH]
- req_last  input  N_REQ  marks final beat of requester's burst
- req_ready  output  N_REQ  per-requester accept; one-hot or zero
- wfull  input  1  registered FIFO full flag
- half_full  input  1  registered FIFO half-full flag
- winc  output  1  FIFO write strobe
- wdata  output  DATA_WIDTH  FIFO write data
- grant_id  output  $clog2(N_REQ)  currently/last granted requester
- busy  output  1  1 while in BURST

Behaviour:
- State machine: IDLE, BURST. All state registered on posedge wclk.
- wrst=1 (synchronous, any state, mid-burst included) sets next cycle:
  - state=IDLE, rr_ptr=0, grant_id=0, beat_cnt=0, busy=0.
  - winc=0, req_ready=0; wdata don't-care (driven from grant_id 0).
  - An in-flight burst is abandoned; no beat is written in the reset cycle.
- IDLE:
  - eligible = req_valid & (half_full ? PRIO_MASK : all ones).
  - If eligible != 0: pick the first set bit scanning upward from rr_ptr with wrap. Register grant_id=pick, beat_cnt=0, go BURST.
  - If eligible == 0: stay in IDLE.
  - Outputs in IDLE: winc=0, req_ready=0. Arbitration costs one cycle; first write is at earliest the cycle after the request is seen.
- BURST, with g=grant_id:
  - req_ready[g]=~wfull; all other req_ready bits 0.
  - winc = req_valid[g] & ~wfull (combinational).
  - wdata = req_data[g] (combinational).
  - Accepted beat = winc=1; beat_cnt increments on each accepted beat.
- Leave BURST for IDLE when any of these holds:
  - accepted beat with req_last[g]=1;
  - accepted beat with beat_cnt==MAX_BURST-1;
  - req_valid[g]=0 (bubble ends the grant).
- On exit: rr_ptr = (g+1) mod N_REQ, busy=0.
- wfull=1 in BURST: stall. No winc, no count, grant held; burst resumes when wfull drops.
- half_full toggling mid-burst has no effect on the current grant; it is sampled only in IDLE.
- Simultaneous last and MAX_BURST: single exit, same as either alone.
- req_last on a non-accepted cycle (wfull=1) is ignored.
- No winc is ever issued while wfull=1, so FIFO overflow is impossible.
- beat_cnt width: $clog2(MAX_BURST+1).

Optional Feature:
- Macro FIFO_WR_ARB_STALL_CNT_EN.
- Defined:
  - Extra output stall_cnt [15:0].
  - Increments each BURST cycle with req_valid[grant_id]=1 and wfull=1.
  - Saturates at 16'hFFFF; cleared by wrst.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Package fifo_arb_pkg:
  - state enum arb_state_t {IDLE, BURST};
  - localparam STALL_CNT_W=16;
  - function grant_w(n) returning $clog2(n).
- One sub-module, rr_pick: combinational rotating-priority picker.
  - Inputs: eligible vector, rr_ptr.
  - Outputs: pick index, any.
  - Instantiated once.

Test Plan:
- Reset mid-burst: requester 1 granted, 3 beats accepted, wrst=1 one cycle -> next cycle busy=0, winc=0, grant_id=0. Post-reset grant scan restarts from requester 0.
- Round-robin: all 4 requesters valid, each bursts 2 beats with last on beat 2 -> grant order 0,1,2,3,0. Exactly 8 winc per round; one idle cycle between bursts.
- MAX_BURST=16: requester 2 streams 20 beats with no last -> grant released after 16 winc, next grant to 3. Requester 2 regains its grant after the rotation.
- wfull stall: during a requester 0 burst, wfull=1 for 5 cycles -> winc=0 and req_ready[0]=0 for those cycles, beat_cnt frozen; resumes with the same grant. With the macro, stall_cnt=5.
- half_full gating: half_full=1, req_valid=4'b1110, PRIO_MASK=4'b0001 -> no grant, busy=0. Then req_valid[0]=1 -> requester 0 granted next cycle.
- half_full rises mid-burst of requester 3 -> burst completes through last. Afterwards only PRIO_MASK requesters are granted.
